// File: rtl/ttl_latch_sync.sv
// 74x373/374-style latch/register with emulated output propagation delay.
// Optional TTL_LATCH_BUSHOLD_EN: disabled outputs hold the last enabled value instead of 0.
module ttl_latch_sync #(
  parameter int WIDTH   = 8,
  parameter int MODE    = 0,
  parameter int DLY_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             OCn,
  input  logic             C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Q_oe
);

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             load;
  logic [WIDTH-1:0] v;
  logic             e;

  // MODE 1 loads only on the first cycle of a high C; c_q resets high so a C held
  // across reset release is not mistaken for a rising edge.
  always_comb begin
    c_d  = C;
    load = 1'b0;
    if (MODE == 0) load = C;
    else           load = C & ~c_q;
    s_d  = load ? D : s_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b1;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

`ifdef TTL_LATCH_BUSHOLD_EN
  logic [WIDTH-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = OCn ? hold_q : s_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign v = OCn ? hold_q : s_q;
`else
  assign v = OCn ? '0 : s_q;
`endif

  assign e = ~OCn;

  generate
    if (DLY_CYC == 0) begin : g_comb
      // Outputs are combinational here, so reset must force them low directly.
      assign Q    = rst ? '0 : v;
      assign Q_oe = ~rst & e;
    end else begin : g_pipe
      logic [DLY_CYC-1:0][WIDTH-1:0] pv_q, pv_d;
      logic [DLY_CYC-1:0]            pe_q, pe_d;

      always_comb begin
        pv_d    = pv_q;
        pe_d    = pe_q;
        pv_d[0] = v;
        pe_d[0] = e;
        for (int i = 1; i < DLY_CYC; i++) begin
          pv_d[i] = pv_q[i-1];
          pe_d[i] = pe_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv_q <= '0;
          pe_q <= '0;
        end else begin
          pv_q <= pv_d;
          pe_q <= pe_d;
        end
      end

      assign Q    = pv_q[DLY_CYC-1];
      assign Q_oe = pe_q[DLY_CYC-1];
    end
  endgenerate

endmodule
